// File: rtl/spi_host_sequencer.sv
// spi_host_sequencer: accepts parallel read/write requests and expands each
// into the SPI_wrapper two-frame protocol (address frame, then data frame),
// capturing the byte returned on MISO for reads. All outputs are registered.
module spi_host_sequencer #(
    parameter int ADDR_SIZE  = 8,
    parameter int RD_LAT     = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [ADDR_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [ADDR_SIZE-1:0] rsp_rdata,
    output logic                 busy,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);

    // frame word is {cmd[1:0], payload}, shifted MSB first
    localparam int W    = ADDR_SIZE + 2;
    localparam int M1   = (W > RD_LAT) ? W : RD_LAT;
    localparam int CMAX = (M1 > GAP_CYCLES) ? M1 : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    // counters load "cycles - 1" and count down to zero
    localparam logic [CW-1:0] SHIFT_LAST = CW'(W - 1);
    localparam logic [CW-1:0] RDW_LAST   = CW'(RD_LAT - 1);
    localparam logic [CW-1:0] CAP_LAST   = CW'(ADDR_SIZE - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        SHIFT   = 3'd2,
        RD_WAIT = 3'd3,
        CAPTURE = 3'd4,
        GAP     = 3'd5
    } state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic                  phase, phase_nx;
    logic                  lat_wr, wr_nx;
    logic [ADDR_SIZE-1:0]  lat_addr, addr_nx;
    logic [ADDR_SIZE-1:0]  lat_wdata, wdata_nx;
    logic [ADDR_SIZE-1:0]  cap;
    logic                  rsp_valid_nx;
    logic [ADDR_SIZE-1:0]  rsp_rdata_nx;
    logic [ADDR_SIZE-1:0]  payload_nx;
    logic [W-1:0]          word_nx;
    logic                  ss_n_nx, mosi_nx;

    // next state, next latched fields and next registered pin values
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        phase_nx     = phase;
        wr_nx        = lat_wr;
        addr_nx      = lat_addr;
        wdata_nx     = lat_wdata;
        rsp_valid_nx = 1'b0;
        rsp_rdata_nx = rsp_rdata;
        payload_nx   = '0;
        word_nx      = '0;
        ss_n_nx      = 1'b1;
        mosi_nx      = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nx = START;
                    phase_nx = 1'b0;
                    wr_nx    = req_wr;
                    addr_nx  = req_addr;
                    wdata_nx = req_wdata;
                end
            end
            START: begin
                state_nx = SHIFT;
                cnt_nx   = SHIFT_LAST;
            end
            SHIFT: begin
                if (cnt == '0) begin
                    // only the read-data frame waits for and captures MISO
                    if (!lat_wr && phase) begin
                        if (RD_LAT > 0) begin
                            state_nx = RD_WAIT;
                            cnt_nx   = RDW_LAST;
                        end else begin
                            state_nx = CAPTURE;
                            cnt_nx   = CAP_LAST;
                        end
                    end else begin
                        state_nx = GAP;
                        cnt_nx   = GAP_LAST;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            RD_WAIT: begin
                if (cnt == '0) begin
                    state_nx = CAPTURE;
                    cnt_nx   = CAP_LAST;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            CAPTURE: begin
                if (cnt == '0) begin
                    state_nx     = GAP;
                    cnt_nx       = GAP_LAST;
                    rsp_valid_nx = 1'b1;
                    rsp_rdata_nx = {cap[ADDR_SIZE-2:0], MISO};
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    if (!phase) begin
                        state_nx = START;
                        phase_nx = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        phase_nx = 1'b0;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // word for the frame being entered; fields come from the new latch
        // values so the accept edge already drives the right START bit
        if (phase_nx) payload_nx = wr_nx ? wdata_nx : '0;
        else          payload_nx = addr_nx;
        word_nx = {~wr_nx, phase_nx, payload_nx};

        ss_n_nx = (state_nx == IDLE) || (state_nx == GAP);
        if (state_nx == START) begin
            mosi_nx = word_nx[W-1];
        end else if (state_nx == SHIFT) begin
            for (int i = 0; i < W; i++) begin
                if (cnt_nx == CW'(i)) mosi_nx = word_nx[i];
            end
        end
    end

    // state, latched request and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            phase     <= 1'b0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cap       <= '0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            phase     <= phase_nx;
            lat_wr    <= wr_nx;
            lat_addr  <= addr_nx;
            lat_wdata <= wdata_nx;
            if (state == CAPTURE) cap <= {cap[ADDR_SIZE-2:0], MISO};
            SS_n      <= ss_n_nx;
            MOSI      <= mosi_nx;
            req_ready <= (state_nx == IDLE);
            busy      <= (state_nx != IDLE);
            rsp_valid <= rsp_valid_nx;
            rsp_rdata <= rsp_rdata_nx;
        end
    end

endmodule

// File: tb/tb_spi_host_sequencer.sv
// Bench for spi_host_sequencer: a request-level reference model predicts the
// frames, busy length and read data; a serial-side device model answers reads.
module tb_spi_host_sequencer;

    localparam int AS     = 8;
    localparam int RD_LAT = 2;
    localparam int GAP    = 2;
    localparam int W      = AS + 2;
    localparam int B2B_N  = 4;
    localparam int M_IDLE  = 0;  // drop valid, scramble inputs until idle
    localparam int M_HOLD  = 1;  // keep valid high for the next request
    localparam int M_NORET = 2;  // drop valid, return straight after accept

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_wr = 1'b0;
    logic [AS-1:0] req_addr = '0;
    logic [AS-1:0] req_wdata = '0;
    logic          MISO = 1'b0;
    logic          req_ready, rsp_valid, busy, SS_n, MOSI;
    logic [AS-1:0] rsp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_host_sequencer #(.ADDR_SIZE(AS), .RD_LAT(RD_LAT), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
    );

    typedef struct {
        logic [W-1:0] w;
        int           len;
    } frm_t;

    frm_t          exp_frm[$];
    int            exp_busy[$];
    logic [AS-1:0] exp_rsp[$];
    logic [AS-1:0] ref_ram[256];
    logic [AS-1:0] dev_ram[256];
    int            b2b_cnt = 0;

    function automatic frm_t mk(logic [W-1:0] w, int len);
        frm_t f;
        f.w = w;
        f.len = len;
        return f;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s act=none exp=event", name);
    endtask

    // issue one request; expectations are pushed on the accept edge
    task automatic issue(input bit wr, input logic [AS-1:0] a, input logic [AS-1:0] d, input int mode);
        int n;
        n = 0;
        req_wr = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
        while (!req_ready) begin
            if (++n > 200) begin fail("accept_timeout"); req_valid = 1'b0; return; end
            @(negedge clk);
        end
        @(posedge clk);
        if (wr) begin
            exp_frm.push_back(mk({2'b00, a}, W + 1));
            exp_frm.push_back(mk({2'b01, d}, W + 1));
            exp_busy.push_back(2 * (W + 1 + GAP));
            ref_ram[a] = d;
        end else begin
            exp_frm.push_back(mk({2'b10, a}, W + 1));
            exp_frm.push_back(mk({2'b11, {AS{1'b0}}}, W + 1 + RD_LAT + AS));
            exp_busy.push_back((W + 1 + GAP) + (W + 1 + RD_LAT + AS + GAP));
            exp_rsp.push_back(ref_ram[a]);
        end
        #1;
        if (mode != M_HOLD) req_valid = 1'b0;
        if (mode == M_IDLE) begin
            n = 0;
            forever begin
                @(negedge clk);
                if (req_ready) break;
                if (++n > 200) begin fail("idle_timeout"); break; end
                req_addr = AS'($urandom); req_wdata = AS'($urandom); req_wr = 1'($urandom);
            end
        end
    endtask

    // monitor and device-model state
    bit            m_prev_ss, m_prev_busy, m_prev_rsp, m_start, m_tail_bad;
    int            m_j, m_gap, m_brun, m_irun;
    logic [W-1:0]  m_word;
    logic [AS-1:0] m_dev_addr = '0, m_rd_addr = '0, m_rd_byte = '0, m_last_rsp = '0;
    frm_t          m_f;
    logic [AS-1:0] m_e;

    // sample on the falling edge: decode frames, answer reads, score outputs
    initial begin
        forever begin
            @(negedge clk);
            MISO = 1'($urandom);
            if (!rst_n) begin
                m_prev_ss = 1; m_prev_busy = 0; m_prev_rsp = 0; m_j = 0; m_gap = 1000;
                m_brun = 0; m_irun = 0; m_last_rsp = '0; m_tail_bad = 0;
                continue;
            end
            if (!SS_n) begin
                if (m_prev_ss) begin
                    chk("gap_min", int'(m_gap >= GAP), 1);
                    m_j = 0; m_word = '0; m_tail_bad = 0;
                end
                if (m_j == 0) m_start = MOSI;
                else if (m_j <= W) begin
                    m_word = {m_word[W-2:0], MOSI};
                    if (m_j == W) begin
                        case (m_word[W-1:W-2])
                            2'b00: m_dev_addr = m_word[AS-1:0];
                            2'b01: dev_ram[m_dev_addr] = m_word[AS-1:0];
                            2'b10: m_rd_addr = m_word[AS-1:0];
                            default: m_rd_byte = dev_ram[m_rd_addr];
                        endcase
                    end
                end else if (MOSI) m_tail_bad = 1;
                if (m_j >= W + 1 + RD_LAT && m_j < W + 1 + RD_LAT + AS)
                    MISO = m_rd_byte[AS - 1 - (m_j - (W + 1 + RD_LAT))];
                m_j++;
            end else if (!m_prev_ss) begin
                if (exp_frm.size() == 0) fail("frame_unexpected");
                else begin
                    m_f = exp_frm.pop_front();
                    chk("frame_word", int'(m_word), int'(m_f.w));
                    chk("start_bit", int'(m_start), int'(m_f.w[W-1]));
                    chk("ss_low_len", m_j, m_f.len);
                    chk("tail_mosi", int'(m_tail_bad), 0);
                end
                m_gap = 1;
            end else m_gap++;

            if (rsp_valid) begin
                chk("rsp_pulse_len", int'(m_prev_rsp), 0);
                chk("rsp_first_gap", int'(SS_n && !m_prev_ss), 1);
                if (exp_rsp.size() == 0) fail("rsp_unexpected");
                else begin
                    m_e = exp_rsp.pop_front();
                    chk("rsp_rdata", int'(rsp_rdata), int'(m_e));
                    m_last_rsp = m_e;
                end
            end else chk("rsp_hold", int'(rsp_rdata), int'(m_last_rsp));

            chk("ready_vs_busy", int'(req_ready), int'(!busy));
            if (busy) begin
                if (!m_prev_busy) begin
                    if (b2b_cnt > 0) begin
                        if (b2b_cnt < B2B_N) chk("b2b_idle", m_irun, 1);
                        b2b_cnt--;
                    end
                    m_brun = 1;
                end else m_brun++;
            end else begin
                if (m_prev_busy) begin
                    if (exp_busy.size() == 0) fail("busy_unexpected");
                    else chk("busy_len", m_brun, exp_busy.pop_front());
                    m_irun = 1;
                end else m_irun++;
            end
            m_prev_ss = SS_n; m_prev_busy = busy; m_prev_rsp = rsp_valid;
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog act=running exp=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_ram[i] = AS'($urandom);
            dev_ram[i] = ref_ram[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_ss_n", int'(SS_n), 1);
        chk("rst_mosi", int'(MOSI), 0);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rdata", int'(rsp_rdata), 0);
        chk("rst_busy", int'(busy), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // directed write then read-back
        issue(1'b1, 8'h3C, 8'hA5, M_IDLE);
        issue(1'b0, 8'h3C, 8'h00, M_IDLE);

        // valid held across completions, boundary addresses
        b2b_cnt = B2B_N;
        issue(1'b1, 8'h00, AS'($urandom), M_HOLD);
        issue(1'b1, 8'hFF, AS'($urandom), M_HOLD);
        issue(1'b0, 8'h00, 8'h00, M_HOLD);
        issue(1'b0, 8'hFF, 8'h00, M_IDLE);

        // random traffic over a small address window so reads hit writes
        repeat (24) begin
            issue(1'($urandom), AS'($urandom_range(0, 7)), AS'($urandom), M_IDLE);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // reset in the 5th SHIFT cycle of a read-data frame
        issue(1'b1, 8'h77, 8'hC3, M_IDLE);
        issue(1'b0, 8'h77, 8'h00, M_IDLE);
        issue(1'b0, 8'h77, 8'h00, M_NORET);
        repeat (18) @(posedge clk);
        #2;
        chk("pre_abort_ss", int'(SS_n), 0);
        rst_n = 1'b0;
        #1;
        chk("abort_ss_n", int'(SS_n), 1);
        chk("abort_mosi", int'(MOSI), 0);
        chk("abort_rdata", int'(rsp_rdata), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(req_ready), 1);
        exp_frm.delete(); exp_busy.delete(); exp_rsp.delete(); b2b_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_rsp_valid", int'(rsp_valid), 0);
        end
        #2 rst_n = 1'b1;
        @(negedge clk);

        // fresh traffic after abort
        issue(1'b1, 8'h81, AS'($urandom), M_IDLE);
        issue(1'b0, 8'h81, 8'h00, M_IDLE);
        issue(1'b0, 8'hFF, 8'h00, M_IDLE);

        repeat (3) @(negedge clk);
        chk("frames_left", exp_frm.size(), 0);
        chk("busy_left", exp_busy.size(), 0);
        chk("rsp_left", exp_rsp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
